// File: rtl/sfm_pkg.sv
// Shared types for the softmax cast stages: cast control word, inbound cast
// FSM states and float-format geometry helpers.
package sfm_pkg;

  // Encoding matches fpnew_pkg::fp_format_e so values can be passed through.
  typedef enum logic [2:0] {
    FP32    = 3'd0,
    FP64    = 3'd1,
    FP16    = 3'd2,
    FP8     = 3'd3,
    FP16ALT = 3'd4
  } fp_format_e;

  localparam int unsigned CAST_INT_BITS_W = 6;

  typedef struct packed {
    logic                       enable;
    logic                       is_signed;
    logic [CAST_INT_BITS_W-1:0] int_bits;
  } cast_ctrl_t;

  typedef enum logic {
    EMPTY = 1'b0,
    DRAIN = 1'b1
  } cast_in_state_e;

  function automatic int unsigned fp_exp_bits(fp_format_e fmt);
    case (fmt)
      FP32:    return 8;
      FP64:    return 11;
      FP16:    return 5;
      FP8:     return 5;
      default: return 8;
    endcase
  endfunction

  function automatic int unsigned fp_man_bits(fp_format_e fmt);
    case (fmt)
      FP32:    return 23;
      FP64:    return 52;
      FP16:    return 10;
      FP8:     return 2;
      default: return 7;
    endcase
  endfunction

  function automatic int unsigned fp_width(fp_format_e fmt);
    return 1 + fp_exp_bits(fmt) + fp_man_bits(fmt);
  endfunction

endpackage

// File: rtl/hwpe_stream_intf_stream.sv
// Valid/ready stream with byte strobes.
interface hwpe_stream_intf_stream #(
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;
  logic [STRB_WIDTH-1:0] strb;

  modport source (output valid, data, strb, input ready);
  modport sink   (input valid, data, strb, output ready);
endinterface

// File: rtl/sfm_int2fp.sv
// Single-element fixed-point (q * 2^-F) to float converter, round-to-nearest-even.
module sfm_int2fp import sfm_pkg::*; #(
  parameter int unsigned INT_WIDTH = 8,
  parameter int unsigned EXP_BITS  = 8,
  parameter int unsigned MAN_BITS  = 7
) (
  input  logic [INT_WIDTH-1:0]       i_q,
  input  logic                       i_is_signed,
  input  logic [CAST_INT_BITS_W-1:0] i_int_bits,
  output logic [EXP_BITS+MAN_BITS:0] o_fp
);

  localparam int unsigned FP_WIDTH = 1 + EXP_BITS + MAN_BITS;
  localparam int          BIAS     = 2 ** (EXP_BITS - 1) - 1;
  localparam int unsigned FRAC_W   = INT_WIDTH - 1;

  logic                  w_neg;
  logic [INT_WIDTH-1:0]  w_mag;
  logic [31:0]           w_lead;
  logic [FRAC_W-1:0]     w_frac;
  int                    w_f;
  logic [EXP_BITS-1:0]   w_exp;
  logic [MAN_BITS-1:0]   w_man;
  logic                  w_round;
  logic [FP_WIDTH-2:0]   w_body;

  // Sign/magnitude split, leading-one search and exponent.
  always_comb begin
    w_neg = i_is_signed & i_q[INT_WIDTH-1];
    w_mag = w_neg ? -i_q : i_q;
    w_lead = '0;
    for (int unsigned i = 0; i < INT_WIDTH; i++) begin
      if (w_mag[i]) w_lead = i;
    end
    // Left-justify so the leading one drops off the top; the rest is the fraction.
    w_frac = FRAC_W'(w_mag << (FRAC_W - w_lead));
    w_f    = int'(INT_WIDTH) - int'(i_is_signed) - int'(i_int_bits);
    w_exp  = EXP_BITS'(BIAS + int'(w_lead) - w_f);
  end

  if (FRAC_W <= MAN_BITS) begin : g_exact
    assign w_man   = MAN_BITS'(w_frac) << (MAN_BITS - FRAC_W);
    assign w_round = 1'b0;
  end else begin : g_round
    localparam int unsigned DROP = FRAC_W - MAN_BITS;
    logic w_guard;
    logic w_sticky;
    assign w_man   = w_frac[FRAC_W-1 -: MAN_BITS];
    assign w_guard = w_frac[DROP-1];
    if (DROP > 1) begin : g_sticky
      assign w_sticky = |w_frac[DROP-2:0];
    end else begin : g_nosticky
      assign w_sticky = 1'b0;
    end
    assign w_round = w_guard & (w_sticky | w_man[0]);
  end

  // Rounding increment on {exp,man} lets a mantissa carry bump the exponent.
  always_comb begin
    w_body = {w_exp, w_man} + {{(FP_WIDTH-2){1'b0}}, w_round};
    o_fp   = (w_mag == '0) ? '0 : {w_neg, w_body};
  end

endmodule

// File: rtl/sfm_cast_in.sv
// Inbound cast: buffers one beat of packed integers and serializes it into
// RATIO beats of packed floats, with strobe-driven early termination.
module sfm_cast_in import sfm_pkg::*; #(
  parameter int unsigned DATA_WIDTH = 256,
  parameter fp_format_e  FPFORMAT   = FP16ALT,
  parameter int unsigned INT_WIDTH  = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  cast_ctrl_t             ctrl_i,
  hwpe_stream_intf_stream.sink   stream_i,
  hwpe_stream_intf_stream.source stream_o
);

  localparam int unsigned DATA_W      = DATA_WIDTH;
  localparam int unsigned INT_W       = INT_WIDTH;
  localparam fp_format_e  FPFORMAT_IN = FPFORMAT;
  localparam int unsigned FP_WIDTH    = fp_width(FPFORMAT_IN);
  localparam int unsigned EXP_BITS    = fp_exp_bits(FPFORMAT_IN);
  localparam int unsigned MAN_BITS    = fp_man_bits(FPFORMAT_IN);
  localparam int unsigned NUM_IN      = DATA_W / INT_W;
  localparam int unsigned NUM_OUT     = DATA_W / FP_WIDTH;
  localparam int unsigned RATIO       = NUM_IN / NUM_OUT;
  localparam int unsigned CNT_W       = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int unsigned STRB_W      = DATA_W / 8;
  localparam int unsigned CHUNK_W     = NUM_OUT * INT_W;
  localparam int unsigned CHUNK_B     = CHUNK_W / 8;
  localparam int unsigned INT_B       = INT_W / 8;
  localparam int unsigned FP_B        = FP_WIDTH / 8;

  cast_in_state_e             r_state;
  cast_in_state_e             w_state_nxt;
  logic [DATA_W-1:0]          r_buf_data;
  logic [STRB_W-1:0]          r_buf_strb;
  logic                       r_is_signed;
  logic [CAST_INT_BITS_W-1:0] r_int_bits;
  logic [CNT_W-1:0]           r_cnt;

  logic [CHUNK_W-1:0] w_chunk_data;
  logic [CHUNK_B-1:0] w_chunk_strb;
  logic [DATA_W-1:0]  w_out_data;
  logic [STRB_W-1:0]  w_out_strb;
  logic               w_rest_any;
  logic               w_last;
  logic               w_capture;
  logic               w_advance;

  assign w_chunk_data = r_buf_data[r_cnt*CHUNK_W +: CHUNK_W];
  assign w_chunk_strb = r_buf_strb[r_cnt*CHUNK_B +: CHUNK_B];

  // Any strobe left in chunks beyond the current one decides whether to keep draining.
  always_comb begin
    w_rest_any = 1'b0;
    for (int unsigned c = 0; c < RATIO; c++) begin
      if (c > 32'(r_cnt) && |r_buf_strb[c*CHUNK_B +: CHUNK_B]) w_rest_any = 1'b1;
    end
    w_last = (r_cnt == CNT_W'(RATIO - 1)) || !w_rest_any;
  end

  for (genvar j = 0; j < NUM_OUT; j++) begin : g_elem
    logic [FP_WIDTH-1:0] w_fp;
    logic                w_en;
    sfm_int2fp #(
      .INT_WIDTH (INT_W),
      .EXP_BITS  (EXP_BITS),
      .MAN_BITS  (MAN_BITS)
    ) u_cvt (
      .i_q         (w_chunk_data[j*INT_W +: INT_W]),
      .i_is_signed (r_is_signed),
      .i_int_bits  (r_int_bits),
      .o_fp        (w_fp)
    );
    assign w_en = &w_chunk_strb[j*INT_B +: INT_B];
    assign w_out_data[j*FP_WIDTH +: FP_WIDTH] = w_en ? w_fp : '0;
    assign w_out_strb[j*FP_B +: FP_B]         = {FP_B{w_en}};
  end

  // Next state, handshakes and output mux (bypass when idle and disabled).
  always_comb begin
    w_state_nxt    = r_state;
    w_capture      = 1'b0;
    w_advance      = 1'b0;
    stream_o.valid = 1'b0;
    stream_o.data  = '0;
    stream_o.strb  = '0;
    stream_i.ready = 1'b0;
    unique case (r_state)
      EMPTY: begin
        if (!ctrl_i.enable) begin
          stream_o.valid = stream_i.valid;
          stream_o.data  = stream_i.data;
          stream_o.strb  = stream_i.strb;
          stream_i.ready = stream_o.ready;
        end else begin
          stream_i.ready = 1'b1;
          if (stream_i.valid) begin
            w_capture   = 1'b1;
            w_state_nxt = DRAIN;
          end
        end
      end
      DRAIN: begin
        stream_o.valid = 1'b1;
        stream_o.data  = w_out_data;
        stream_o.strb  = w_out_strb;
        if (stream_o.ready) begin
          if (!w_last) begin
            w_advance = 1'b1;
          end else if (ctrl_i.enable) begin
            // Accept the next beat on the final chunk so back-to-back input has no bubble.
            stream_i.ready = 1'b1;
            if (stream_i.valid) w_capture = 1'b1;
            else                w_state_nxt = EMPTY;
          end else begin
            w_state_nxt = EMPTY;
          end
        end
      end
      default: w_state_nxt = EMPTY;
    endcase
  end

  // State, buffer and chunk counter registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= EMPTY;
      r_buf_data  <= '0;
      r_buf_strb  <= '0;
      r_is_signed <= 1'b0;
      r_int_bits  <= '0;
      r_cnt       <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_capture) begin
        r_buf_data  <= stream_i.data;
        r_buf_strb  <= stream_i.strb;
        r_is_signed <= ctrl_i.is_signed;
        r_int_bits  <= ctrl_i.int_bits;
        r_cnt       <= '0;
      end else if (w_advance) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end else if (w_state_nxt == EMPTY) begin
        r_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_sfm_cast_in.sv
// Bench for sfm_cast_in: 256-bit stream, INT8 in, BF16 out.
module tb_sfm_cast_in;
  import sfm_pkg::*;

  localparam int unsigned DW = 256;

  logic       clk = 1'b0;
  logic       rst;
  cast_ctrl_t ctrl;
  int         errors = 0;
  int         checks = 0;
  bit         mon_en = 1'b0;
  logic [287:0] exp_q[$];
  logic [287:0] mon_exp;
  logic         prev_stall = 1'b0;
  logic [288:0] prev_beat;
  logic         hs;
  logic [255:0] d;
  logic [255:0] e;

  hwpe_stream_intf_stream #(.DATA_WIDTH(DW)) in_s ();
  hwpe_stream_intf_stream #(.DATA_WIDTH(DW)) out_s ();

  sfm_cast_in #(
    .DATA_WIDTH (DW),
    .FPFORMAT   (FP16ALT),
    .INT_WIDTH  (8)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .ctrl_i   (ctrl),
    .stream_i (in_s),
    .stream_o (out_s)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  // Reference: real value q*2^-F, then take the bf16 fields from the double encoding.
  function automatic logic [15:0] bf16_of(logic [7:0] q, logic sgn, int ib);
    int v;
    int ex;
    real r;
    logic [63:0] b;
    v = sgn ? int'($signed(q)) : int'(q);
    if (v == 0) return 16'h0000;
    r = real'(v) / real'(1 << (8 - int'(sgn) - ib));
    b = $realtobits(r);
    ex = int'(b[62:52]) - 1023 + 127;
    return {b[63], ex[7:0], b[51:45]};
  endfunction

  function automatic void push_beat(logic [255:0] din, logic [31:0] s, logic sgn, int ib);
    int last;
    logic [255:0] od;
    logic [31:0] os;
    last = 0;
    for (int c = 0; c < 2; c++) if (|s[c*16 +: 16]) last = c;
    for (int c = 0; c <= last; c++) begin
      od = '0;
      os = '0;
      for (int j = 0; j < 16; j++) begin
        if (s[c*16 + j]) begin
          od[j*16 +: 16] = bf16_of(din[(c*16 + j)*8 +: 8], sgn, ib);
          os[j*2 +: 2]   = 2'b11;
        end
      end
      exp_q.push_back({os, od});
    end
  endfunction

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [287:0] obs, input logic [287:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic send_one(input logic [255:0] din, input logic [31:0] s, input logic sgn, input int ib);
    tick();
    ctrl.enable    = 1'b1;
    ctrl.is_signed = sgn;
    ctrl.int_bits  = 6'(ib);
    in_s.valid = 1'b1;
    in_s.data  = din;
    in_s.strb  = s;
    tick();
    in_s.valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    in_s.valid  = 1'b0;
    out_s.ready = 1'b1;
    while ((out_s.valid || exp_q.size() != 0) && n < 50) begin
      tick();
      n++;
    end
    chk({tag, "_queue"}, 288'(exp_q.size()), 288'(0));
    chk({tag, "_valid"}, 288'(out_s.valid), 288'(0));
  endtask

  // Scoreboard: pops on output handshakes, pushes on captured input beats, checks holds under stall.
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (prev_stall) begin
        checks++;
        assert ({out_s.valid, out_s.strb, out_s.data} === prev_beat) else begin
          errors++;
          $error("FAIL hold observed=%h expected=%h", {out_s.valid, out_s.strb, out_s.data}, prev_beat);
        end
      end
      if (out_s.valid && out_s.ready) begin
        checks++;
        assert (exp_q.size() != 0) else begin
          errors++;
          $error("FAIL sb_extra observed=%h expected=none", {out_s.strb, out_s.data});
        end
        if (exp_q.size() != 0) begin
          mon_exp = exp_q.pop_front();
          checks++;
          assert ({out_s.strb, out_s.data} === mon_exp) else begin
            errors++;
            $error("FAIL sb_beat observed=%h expected=%h", {out_s.strb, out_s.data}, mon_exp);
          end
        end
      end
      if (in_s.valid && in_s.ready && ctrl.enable)
        push_beat(in_s.data, in_s.strb, ctrl.is_signed, int'(ctrl.int_bits));
      prev_stall = out_s.valid && !out_s.ready;
      prev_beat  = {out_s.valid, out_s.strb, out_s.data};
    end else begin
      prev_stall = 1'b0;
    end
  end

  initial begin
    rst            = 1'b1;
    ctrl.enable    = 1'b1;
    ctrl.is_signed = 1'b0;
    ctrl.int_bits  = '0;
    in_s.valid     = 1'b0;
    in_s.data      = '0;
    in_s.strb      = '0;
    out_s.ready    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst    = 1'b0;
    mon_en = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst_out_valid", 288'(out_s.valid), 288'(0));
    chk("rst_in_ready", 288'(in_s.ready), 288'(1));

    // Unsigned, int_bits=1, all 0x40 -> every element 0.5
    tick();
    ctrl.is_signed = 1'b0;
    ctrl.int_bits  = 6'd1;
    in_s.valid = 1'b1;
    in_s.data  = {32{8'h40}};
    in_s.strb  = '1;
    @(negedge clk);
    chk("t1_in_ready", 288'(in_s.ready), 288'(1));
    chk("t1_pre_valid", 288'(out_s.valid), 288'(0));
    tick();
    in_s.valid = 1'b0;
    @(negedge clk);
    chk("t1_beat0_valid", 288'(out_s.valid), 288'(1));
    chk("t1_beat0", {out_s.strb, out_s.data}, {32'hFFFF_FFFF, {16{16'h3F00}}});
    tick();
    @(negedge clk);
    chk("t1_beat1_valid", 288'(out_s.valid), 288'(1));
    chk("t1_beat1", {out_s.strb, out_s.data}, {32'hFFFF_FFFF, {16{16'h3F00}}});
    tick();
    @(negedge clk);
    chk("t1_done_valid", 288'(out_s.valid), 288'(0));

    // Signed, int_bits=0: -128, 127, 0, 1 repeating
    for (int i = 0; i < 32; i++) begin
      case (i % 4)
        0:       d[i*8 +: 8] = 8'h80;
        1:       d[i*8 +: 8] = 8'h7F;
        2:       d[i*8 +: 8] = 8'h00;
        default: d[i*8 +: 8] = 8'h01;
      endcase
    end
    for (int j = 0; j < 16; j++) begin
      case (j % 4)
        0:       e[j*16 +: 16] = 16'hBF80;
        1:       e[j*16 +: 16] = 16'h3F7E;
        2:       e[j*16 +: 16] = 16'h0000;
        default: e[j*16 +: 16] = 16'h3C00;
      endcase
    end
    send_one(d, '1, 1'b1, 0);
    @(negedge clk);
    chk("t2_signed_beat0", {out_s.strb, out_s.data}, {32'hFFFF_FFFF, e});
    tick();
    @(negedge clk);
    chk("t2_signed_beat1", {out_s.strb, out_s.data}, {32'hFFFF_FFFF, e});
    wait_idle("t2_idle");

    // Unsigned, int_bits=0, 0xFF
    send_one({32{8'hFF}}, '1, 1'b0, 0);
    @(negedge clk);
    chk("t2_uns_ff", {out_s.strb, out_s.data}, {32'hFFFF_FFFF, {16{16'h3F7F}}});
    wait_idle("t2b_idle");

    // Back-to-back input with a free output: ready every second cycle, no gaps
    tick();
    ctrl.is_signed = 1'b0;
    ctrl.int_bits  = 6'd3;
    out_s.ready = 1'b1;
    in_s.valid  = 1'b1;
    in_s.strb   = '1;
    in_s.data   = rnd256();
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("b2b_in_ready", 288'(in_s.ready), 288'((k % 2) == 0));
      chk("b2b_out_valid", 288'(out_s.valid), 288'(k > 0));
      hs = in_s.ready;
      tick();
      if (hs) in_s.data = rnd256();
    end
    wait_idle("b2b_idle");

    // Random stalls, random data/strobes/ctrl
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      hs = in_s.valid && in_s.ready;
      tick();
      out_s.ready = ($urandom_range(0, 3) != 0);
      if (!in_s.valid || hs) begin
        in_s.valid = ($urandom_range(0, 2) != 0);
        in_s.data  = rnd256();
        case ($urandom_range(0, 2))
          0:       in_s.strb = '1;
          1:       in_s.strb = 32'h0000_FFFF;
          default: in_s.strb = $urandom;
        endcase
      end
      ctrl.is_signed = 1'($urandom_range(0, 1));
      ctrl.int_bits  = 6'($urandom_range(0, 8 - int'(ctrl.is_signed)));
    end
    wait_idle("rnd_idle");

    // Upper half strobed off: one beat only; byte 3 off -> zero element, zero strobe
    e = {16{16'h3F00}};
    e[63:48] = 16'h0000;
    send_one({32{8'h40}}, 32'h0000_FFF7, 1'b0, 1);
    @(negedge clk);
    chk("early_beat", {out_s.strb, out_s.data}, {32'hFFFF_FF3F, e});
    tick();
    @(negedge clk);
    chk("early_done_valid", 288'(out_s.valid), 288'(0));
    chk("early_in_ready", 288'(in_s.ready), 288'(1));
    wait_idle("early_idle");

    // Bypass: output follows input combinationally
    mon_en = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      ctrl.enable = 1'b0;
      in_s.valid  = 1'($urandom_range(0, 1));
      in_s.data   = rnd256();
      in_s.strb   = $urandom;
      out_s.ready = 1'($urandom_range(0, 1));
      #1;
      chk("byp_data", {out_s.strb, out_s.data}, {in_s.strb, in_s.data});
      chk("byp_valid", 288'(out_s.valid), 288'(in_s.valid));
      chk("byp_ready", 288'(in_s.ready), 288'(out_s.ready));
    end
    tick();
    in_s.valid  = 1'b0;
    ctrl.enable = 1'b1;
    mon_en      = 1'b1;

    // Reset while draining: remaining chunk is dropped
    out_s.ready = 1'b0;
    send_one(rnd256(), '1, 1'b0, 2);
    @(negedge clk);
    chk("rst_mid_pre_valid", 288'(out_s.valid), 288'(1));
    tick();
    mon_en = 1'b0;
    exp_q.delete();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    out_s.ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_mid_valid", 288'(out_s.valid), 288'(0));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
